// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_ctrl_pkg: shared state encoding and default operand width
// for the bit-serial subtraction controller.
package serial_sub_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if: start/busy/done handshake plus operand and result bus.
// Optional macro SERIAL_SUB_OVF_EN adds the signed overflow flag ovf.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_sub_ctrl_full_subtractor.sv
// full_subtractor: single-bit combinational full-subtractor cell,
// computes A - B - C.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ C;
    assign Bout = (~A & B) | (~(A ^ B) & C);

endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed overflow flag.
//
// state | meaning
// IDLE  | waiting for start; diff/bout hold the last result
// RUN   | one operand bit processed per cycle, busy high
// DONE  | one-cycle done pulse; start here chains straight into RUN
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    serial_sub_ctrl_if.slave  bus
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg_a;
    logic [WIDTH-1:0] shreg_b;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             fs_d;
    logic             fs_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    full_subtractor u_fs (
        .A    (shreg_a[0]),
        .B    (shreg_b[0]),
        .C    (borrow),
        .Diff (fs_d),
        .Bout (fs_bo)
    );

    // Controller FSM: operand shifting, borrow chain and result capture.
    // On the last bit shreg_a[0]/shreg_b[0] are the operand MSBs and fs_d is
    // the result MSB, so overflow needs no extra copies of the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg_a <= '0;
            shreg_b <= '0;
            res     <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                RUN: begin
                    borrow  <= fs_bo;
                    shreg_a <= shreg_a >> 1;
                    shreg_b <= shreg_b >> 1;
                    res     <= {fs_d, res[WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        diff_q <= {fs_d, res[WIDTH-1:1]};
                        bout_q <= fs_bo;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q  <= (shreg_a[0] != shreg_b[0]) && (fs_d != shreg_a[0]);
`endif
                    end
                end
                default: begin
                    if (bus.start) begin
                        state   <= RUN;
                        shreg_a <= bus.a;
                        shreg_b <= bus.b;
                        borrow  <= 1'b0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed table, hand-written corner sequences and
// randomized operations against an arithmetic reference model.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs [6];

    int checks = 0;
    int errors = 0;

    logic [W-1:0] held_d;
    logic         held_b;
    logic         held_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        longint sa, sb, r, smax, smin;
        d    = a - b;
        bo   = (a < b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        r    = sa - sb;
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        ov   = (r > smax) || (r < smin);
    endfunction

    // Called at a negedge; start is seen by the following posedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom());
        bus.b     = W'($urandom());
    endtask

    // Entered at the first RUN negedge; returns at the done negedge.
    task automatic collect(input string name, input logic [W-1:0] ed, input logic eb,
                           input logic eo, input int mid_k,
                           input logic [W-1:0] ma, input logic [W-1:0] mb);
        int k  = 1;
        int bc = 0;
        while (!bus.done && k <= 3 * W) begin
            if (bus.busy) bc++;
            if (k == 1 || k == W) begin
                chk({name, "_held_diff"}, 32'(bus.diff), 32'(held_d));
                chk({name, "_held_bout"}, 32'(bus.bout), 32'(held_b));
            end
            if (k == mid_k) begin
                bus.start = 1'b1;
                bus.a     = ma;
                bus.b     = mb;
            end
            @(negedge clk);
            bus.start = 1'b0;
            k++;
        end
        chk({name, "_done"},    32'(bus.done), 32'd1);
        chk({name, "_latency"}, 32'(k),        32'(W + 1));
        chk({name, "_busycnt"}, 32'(bc),       32'(W));
        chk({name, "_busy0"},   32'(bus.busy), 32'd0);
        chk({name, "_diff"},    32'(bus.diff), 32'(ed));
        chk({name, "_bout"},    32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({name, "_ovf"},     32'(bus.ovf),  32'(eo));
`endif
        held_d = ed;
        held_b = eb;
        held_o = eo;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({name, "_idle_busy"},  32'(bus.busy), 32'd0);
        chk({name, "_idle_diff"},  32'(bus.diff), 32'(held_d));
    endtask

    initial begin
        logic [W-1:0] ra, rb, rd;
        logic         rbo, rov;
        int           mk;

        vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bo: 1'b1, ov: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0};

        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h11;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf",  32'(bus.ovf),  32'd0);
`endif
        rst       = 1'b0;
        bus.start = 1'b0;
        held_d    = '0;
        held_b    = 1'b0;
        held_o    = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b);
            collect($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].ov, 0, '0, '0);
            @(negedge clk);
            check_idle($sformatf("vec%0d", i));
        end

        // start during RUN is ignored
        launch(8'h20, 8'h05);
        collect("ign", 8'h1B, 1'b0, 1'b0, 4, 8'h01, 8'h02);
        @(negedge clk);
        check_idle("ign");
        @(negedge clk);
        check_idle("ign2");

        // back-to-back through the DONE cycle
        launch(8'h33, 8'h11);
        collect("b2b_first", 8'h22, 1'b0, 1'b0, 0, '0, '0);
        launch(8'h10, 8'h01);
        collect("b2b_second", 8'h0F, 1'b0, 1'b0, 0, '0, '0);
        @(negedge clk);
        check_idle("b2b");

        // reset in the fifth RUN cycle
        launch(8'h55, 8'h0A);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_bout", 32'(bus.bout), 32'd0);
        held_d = '0;
        held_b = 1'b0;
        held_o = 1'b0;
        repeat (W) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        launch(8'h09, 8'h04);
        collect("after_abort", 8'h05, 1'b0, 1'b0, 0, '0, '0);
        @(negedge clk);
        check_idle("after_abort");

        // randomized operations, sometimes chained, sometimes with ignored starts
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom());
            rb = W'($urandom());
            if ((i % 8) == 0) rb = ra;
            model(ra, rb, rd, rbo, rov);
            mk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            launch(ra, rb);
            collect($sformatf("rnd%0d", i), rd, rbo, rov, mk, W'($urandom()), W'($urandom()));
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                check_idle($sformatf("rnd%0d", i));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller. Computes a − b on WIDTH-bit operands, one bit per clock, LSB first.
- Each step uses one single-bit full-subtractor cell and a registered borrow.
- Provides a start/busy/done handshake for multi-cycle arithmetic in area-constrained datapaths.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock; the block uses this one clock only
rst  input  1  synchronous, active-high reset
start  input  1  request a new subtraction; sampled only when accepting (IDLE or DONE state)
a  input  WIDTH  minuend; sampled in the cycle start is accepted
b  input  WIDTH  subtrahend; sampled in the cycle start is accepted
busy  output  1  high while the RUN state is active
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  result a − b modulo 2^WIDTH; held after done
bout  output  1  final borrow out (1 when a < b unsigned); held after done
ovf  output  1  signed overflow flag (present only with the optional feature)

Behaviour:
- Reset: on rst=1 at a clk edge:
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, bout = 0, ovf = 0.
  - Internal shift registers, borrow and bit counter cleared.
  - rst has priority over all other inputs.
- FSM states and transitions:
  - IDLE: if start=1, latch a into shreg_a and b into shreg_b, clear borrow and counter, go to RUN.
  - RUN: busy=1 each cycle. Bit = FS(shreg_a[0], shreg_b[0], borrow) gives d and bo.
    - borrow <= bo.
    - shreg_a and shreg_b shift right by 1.
    - Result shift register shifts right, with d inserted at the MSB.
    - Counter increments.
    - When the counter reaches WIDTH−1 (the last bit is being processed), go to DONE.
  - DONE: one cycle. done=1, busy=0. diff holds the full result and bout the final borrow.
    - If start=1 in this cycle, the new operands are accepted and the next state is RUN (back-to-back operation).
    - Otherwise the next state is IDLE.
- Latency: start accepted at edge N → busy high for cycles N+1 .. N+WIDTH → done high in cycle N+WIDTH+1. For WIDTH=8, done comes 9 cycles after start.
- Throughput: one result per WIDTH+1 cycles with back-to-back start.
- diff and bout update only when entering DONE. They keep their values through IDLE and through the next RUN until the next DONE.
- start while in RUN is ignored; no queuing.
- a and b may change freely after the accepting edge.
- Counter width is clog2(WIDTH). It must not wrap before the transition to DONE.
- rst during RUN aborts the operation:
  - No done pulse is produced.
  - diff and bout are cleared.
- Arithmetic: unsigned modulo-2^WIDTH subtraction. The borrow-in of bit 0 is always 0.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - The ovf port exists.
  - ovf = (a_msb ≠ b_msb) AND (diff_msb ≠ a_msb), evaluated on the latched operands.
  - ovf is registered together with diff at entry to DONE, held likewise, and cleared by rst.
- When undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package contains:
  - State encoding typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- One natural sub-module: full_subtractor, purely combinational with ports A, B, C → Diff, Bout.
  - Diff = A^B^C.
  - Bout = (~A&B) | (~(A^B)&C).
  - Instantiated once; the controller owns all registers.

Test Plan:
- Reset, then a=0x05, b=0x03, start pulse → busy high 8 cycles, done in cycle 9, diff=0x02, bout=0, ovf=0.
- a=0x03, b=0x05 → diff=0xFE, bout=1. a=0x00, b=0xFF → diff=0x01, bout=1.
- (SERIAL_SUB_OVF_EN) a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- start asserted again at cycle 4 of RUN with different operands → ignored. Original result delivered, exactly one done pulse.
- start held during the DONE cycle with a=0x10, b=0x01 → next RUN begins immediately, second done 9 cycles later with diff=0x0F. Previous diff held until then.
- rst asserted at cycle 5 of RUN → next cycle busy=0, done=0, diff=0, bout=0, state IDLE. A subsequent start operates normally.
